// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results wait in a
// one-entry buffer, and a pending scoreboard raises stall_o on hazards against outstanding MDU ops.
module regfile_wb_arbiter #(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  chk_rs1_i,
  input  logic [4:0]  chk_rs2_i,
  input  logic [4:0]  chk_rd_i,
  output logic        stall_o,
  output logic        full_o,
  output logic        hold_o,
  output logic [31:0] pending_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_data_o
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} buf_state_t;

  buf_state_t        state, state_nxt;
  logic [4:0]        buf_rd;
  logic [DATA_W-1:0] buf_data;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [31:0]       pending, pending_nxt;
  logic              pipe_act, grant, latch, drop, inc, dec;

  assign pipe_act = pipe_we_i && (pipe_rd_i != 5'd0);

  // Buffer FSM: a result to x0 is accepted but discarded without occupying the buffer.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    drop      = 1'b0;
    grant     = 1'b0;
    case (state)
      EMPTY: begin
        if (mdu_valid_i) begin
          if (mdu_rd_i != 5'd0) begin
            latch     = 1'b1;
            state_nxt = HELD;
          end else begin
            drop = 1'b1;
          end
        end
      end
      HELD: begin
        if (!pipe_act) begin
          grant     = 1'b1;
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    rf_we_o   = 1'b0;
    rf_rd_o   = 5'd0;
    rf_data_o = '0;
    if (pipe_act) begin
      rf_we_o   = 1'b1;
      rf_rd_o   = pipe_rd_i;
      rf_data_o = pipe_data_i;
    end else if (state == HELD) begin
      rf_we_o   = 1'b1;
      rf_rd_o   = buf_rd;
      rf_data_o = buf_data;
    end
  end

  assign inc = issue_i && (count < MAX_CNT);
  assign dec = grant || drop;

  always_comb begin
    count_nxt = count;
    case ({inc, dec})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = (count == '0) ? count : count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Set is applied after clear so a re-issue to the register being written stays pending.
  always_comb begin
    pending_nxt = pending;
    if (grant)
      pending_nxt[buf_rd] = 1'b0;
    if (inc && (issue_rd_i != 5'd0))
      pending_nxt[issue_rd_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    wait_nxt = '0;
    if ((state == HELD) && pipe_act)
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= EMPTY;
      count    <= '0;
      pending  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      pending  <= pending_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (latch) begin
      buf_rd   <= mdu_rd_i;
      buf_data <= mdu_data_i;
    end
  end

  assign mdu_ready_o = (state == EMPTY);
  assign full_o      = (count == MAX_CNT);
  assign hold_o      = (state == HELD) && (wait_cnt >= WAIT_MAX);
  assign pending_o   = pending;
  assign stall_o     = full_o | pending[chk_rs1_i] | pending[chk_rs2_i] | pending[chk_rd_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic, all outputs
// compared each cycle against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int MAX_OUT      = 4;
  localparam int STARVE_LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pipe_we_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  chk_rs1_i, chk_rs2_i, chk_rd_i;
  logic        stall_o, full_o, hold_o;
  logic [31:0] pending_o;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;

  int n_checks = 0;
  int n_err    = 0;

  regfile_wb_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
    .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
    .mdu_ready_o(mdu_ready_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .chk_rs1_i(chk_rs1_i), .chk_rs2_i(chk_rs2_i), .chk_rd_i(chk_rd_i),
    .stall_o(stall_o), .full_o(full_o), .hold_o(hold_o), .pending_o(pending_o),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: outstanding count, pending set, buffered result queue, lost-cycle count.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        m_buf[$];
  int          m_cnt;
  int          m_wait;
  logic [31:0] m_pend;

  task automatic model_reset();
    m_buf.delete();
    m_cnt  = 0;
    m_wait = 0;
    m_pend = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    bit          pa, e_we, e_full, e_stall, e_hold;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    pa     = pipe_we_i && (pipe_rd_i != 0);
    e_we   = 1'b0;
    e_rd   = 5'd0;
    e_data = 32'd0;
    if (pa) begin
      e_we = 1'b1; e_rd = pipe_rd_i; e_data = pipe_data_i;
    end else if (m_buf.size() != 0) begin
      e_we = 1'b1; e_rd = m_buf[0].rd; e_data = m_buf[0].data;
    end
    e_full  = (m_cnt == MAX_OUT);
    e_stall = e_full || m_pend[chk_rs1_i] || m_pend[chk_rs2_i] || m_pend[chk_rd_i];
    e_hold  = (m_buf.size() != 0) && (m_wait >= STARVE_LIMIT);
    chk("m_rf_we", {31'd0, rf_we_o}, {31'd0, e_we});
    chk("m_rf_rd", {27'd0, rf_rd_o}, {27'd0, e_rd});
    chk("m_rf_data", rf_data_o, e_data);
    chk("m_ready", {31'd0, mdu_ready_o}, {31'd0, m_buf.size() == 0});
    chk("m_full", {31'd0, full_o}, {31'd0, e_full});
    chk("m_stall", {31'd0, stall_o}, {31'd0, e_stall});
    chk("m_hold", {31'd0, hold_o}, {31'd0, e_hold});
    chk("m_pending", pending_o, m_pend);
  endtask

  task automatic model_step();
    bit   pa, held;
    int   c;
    ent_t e;
    if (rst_i) begin
      model_reset();
      return;
    end
    pa   = pipe_we_i && (pipe_rd_i != 0);
    held = (m_buf.size() != 0);
    c    = m_cnt;
    if (held && !pa) begin
      m_pend[m_buf[0].rd] = 1'b0;
      c--;
      m_buf.delete();
      m_wait = 0;
    end else if (held) begin
      m_wait++;
    end else begin
      m_wait = 0;
    end
    if (!held && mdu_valid_i) begin
      if (mdu_rd_i != 0) begin
        e.rd = mdu_rd_i; e.data = mdu_data_i;
        m_buf.push_back(e);
      end else begin
        c--;
      end
    end
    if (issue_i && m_cnt < MAX_OUT) begin
      c++;
      if (issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
    end
    m_cnt = (c < 0) ? 0 : c;
  endtask

  task automatic tick();
    @(negedge clk_i);
    compare_all();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
    mdu_valid_i = 0; mdu_rd_i = 0; mdu_data_i = 0;
    issue_i = 0; issue_rd_i = 0;
    chk_rs1_i = 0; chk_rs2_i = 0; chk_rd_i = 0;
  endtask

  task automatic mdu_result(input logic [4:0] rd, input logic [31:0] data);
    mdu_valid_i = 1; mdu_rd_i = rd; mdu_data_i = data;
    tick();
    mdu_valid_i = 0;
    tick();
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    #1;
    chk("rst_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_ready", {31'd0, mdu_ready_o}, 32'd1);
    chk("rst_pending", pending_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_full_hold", {30'd0, full_o, hold_o}, 32'd0);
    tick();
    rst_i = 0;
    tick();
    chk("idle_we", {31'd0, rf_we_o}, 32'd0);
    chk("idle_ready", {31'd0, mdu_ready_o}, 32'd1);

    // Basic MDU round trip to r5
    issue_i = 1; issue_rd_i = 5;
    tick();
    issue_i = 0;
    chk("pend5_set", {31'd0, pending_o[5]}, 32'd1);
    tick();
    tick();
    mdu_valid_i = 1; mdu_rd_i = 5; mdu_data_i = 32'hDEADBEEF;
    tick();
    mdu_valid_i = 0;
    chk("wb5_we", {31'd0, rf_we_o}, 32'd1);
    chk("wb5_rd", {27'd0, rf_rd_o}, 32'd5);
    chk("wb5_data", rf_data_o, 32'hDEADBEEF);
    tick();
    chk("wb5_pend_clr", pending_o, 32'd0);
    chk("wb5_not_full", {31'd0, full_o}, 32'd0);

    // Starvation of buffered r7 by pipeline writes to r3
    issue_i = 1; issue_rd_i = 7;
    tick();
    issue_i = 0;
    mdu_valid_i = 1; mdu_rd_i = 7; mdu_data_i = 32'h12345678;
    pipe_we_i = 1; pipe_rd_i = 3; pipe_data_i = 32'hA5A50000;
    tick();
    mdu_valid_i = 0;
    for (int i = 0; i < 6; i++) begin
      pipe_data_i = 32'hA5A50000 + i;
      #1;
      chk("starve_rd", {27'd0, rf_rd_o}, 32'd3);
      chk("starve_data", rf_data_o, 32'hA5A50000 + i);
      chk("starve_hold", {31'd0, hold_o}, {31'd0, i >= STARVE_LIMIT});
      tick();
    end
    pipe_we_i = 0;
    #1;
    chk("grant7_rd", {27'd0, rf_rd_o}, 32'd7);
    chk("grant7_data", rf_data_o, 32'h12345678);
    chk("grant7_hold", {31'd0, hold_o}, 32'd1);
    tick();
    chk("hold_fall", {31'd0, hold_o}, 32'd0);
    chk("ready_back", {31'd0, mdu_ready_o}, 32'd1);

    // RAW/WAW detection and x0 exemption
    issue_i = 1; issue_rd_i = 9;
    tick();
    issue_i = 0;
    chk_rs2_i = 9;
    #1 chk("stall_rs2", {31'd0, stall_o}, 32'd1);
    chk_rs2_i = 0;
    #1 chk("stall_x0", {31'd0, stall_o}, 32'd0);
    chk_rd_i = 9;
    #1 chk("stall_waw", {31'd0, stall_o}, 32'd1);
    chk_rd_i = 0;
    mdu_result(9, 32'h99);
    tick();

    // Fill to MAX_OUT, ignored issue when full, drain
    for (int r = 1; r <= 4; r++) begin
      issue_i = 1; issue_rd_i = 5'(r);
      tick();
    end
    issue_i = 0;
    chk("full_set", {31'd0, full_o}, 32'd1);
    chk("full_stall", {31'd0, stall_o}, 32'd1);
    issue_i = 1; issue_rd_i = 8;
    tick();
    issue_i = 0;
    chk("full_ignore", pending_o, 32'h1E);
    mdu_result(1, 32'h11);
    chk("full_clr", {31'd0, full_o}, 32'd0);
    chk("pend_after1", pending_o, 32'h1C);
    for (int r = 2; r <= 4; r++) mdu_result(5'(r), 32'h100 + r);
    chk("drained", pending_o, 32'd0);

    // Grant and re-issue of r6 in the same cycle
    issue_i = 1; issue_rd_i = 6;
    tick();
    issue_i = 0;
    mdu_valid_i = 1; mdu_rd_i = 6; mdu_data_i = 32'h66;
    tick();
    mdu_valid_i = 0;
    issue_i = 1; issue_rd_i = 6;
    tick();
    issue_i = 0;
    chk("reissue6_pend", pending_o, 32'h40);
    for (int r = 10; r <= 12; r++) begin
      issue_i = 1; issue_rd_i = 5'(r);
      tick();
    end
    issue_i = 0;
    chk("reissue6_count", {31'd0, full_o}, 32'd1);
    mdu_result(6, 32'h660);
    for (int r = 10; r <= 12; r++) mdu_result(5'(r), 32'h200 + r);
    chk("reissue6_drained", pending_o, 32'd0);

    // Random traffic, with occasional mid-run reset
    for (int n = 0; n < 2000; n++) begin
      rst_i       = ($urandom_range(0, 299) == 0);
      pipe_we_i   = ($urandom_range(0, 1) == 1);
      pipe_rd_i   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      pipe_data_i = $urandom;
      mdu_valid_i = ($urandom_range(0, 9) < 3);
      mdu_rd_i    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      mdu_data_i  = $urandom;
      issue_i     = ($urandom_range(0, 3) == 0);
      issue_rd_i  = 5'($urandom);
      chk_rs1_i   = 5'($urandom);
      chk_rs2_i   = 5'($urandom);
      chk_rd_i    = 5'($urandom);
      tick();
    end
    rst_i = 0;
    idle_inputs();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
